// File: rtl/modexp_pkg.sv
// Shared definitions for the modular-exponentiation controller.
// Optional build macro used by the controller: MODEXP_CONST_TIME_EN.
package modexp_pkg;

    // Controller states (3-bit encoding)
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] TO_MONT   = 3'd1;
    localparam logic [2:0] SQ        = 3'd2;
    localparam logic [2:0] MUL       = 3'd3;
    localparam logic [2:0] FROM_MONT = 3'd4;
    localparam logic [2:0] FIN       = 3'd5;

    // Phases of every multiply state
    localparam logic ISSUE = 1'b0;
    localparam logic WAIT  = 1'b1;

    // Operand-select codes for the multiplier inputs
    localparam logic [2:0] SEL_X   = 3'd0;
    localparam logic [2:0] SEL_R2  = 3'd1;
    localparam logic [2:0] SEL_ACC = 3'd2;
    localparam logic [2:0] SEL_XT  = 3'd3;
    localparam logic [2:0] SEL_ONE = 3'd4;

    // Value of the constant operand used to leave the Montgomery domain
    localparam int unsigned ONE = 1;

    // Select code for multiplier operand A in a given state
    function automatic logic [2:0] sel_a(input logic [2:0] st);
        logic [2:0] sel;
        sel = SEL_ACC;
        if (st == TO_MONT) begin
            sel = SEL_X;
        end
        return sel;
    endfunction

    // Select code for multiplier operand B in a given state
    function automatic logic [2:0] sel_b(input logic [2:0] st);
        logic [2:0] sel;
        case (st)
            TO_MONT:   sel = SEL_R2;
            MUL:       sel = SEL_XT;
            FROM_MONT: sel = SEL_ONE;
            default:   sel = SEL_ACC;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/modexp_ebit_iter.sv
// Exponent bit iterator: latches the exponent and walks it from the most
// significant processed bit down to bit 0.
module modexp_ebit_iter
    import modexp_pkg::*;
#(
    parameter int E_WIDTH = 1024
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     load,
    input  logic [E_WIDTH-1:0]       e_in,
    input  logic [$clog2(E_WIDTH):0] len_in,
    input  logic                     step,
    output logic                     cur_bit,
    output logic                     last_bit,
    output logic                     len_zero
);

    localparam int LEN_W = $clog2(E_WIDTH) + 1;
    localparam int IDX_W = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;

    logic [E_WIDTH-1:0] e_bits;
    logic [IDX_W-1:0]   idx;
    logic [LEN_W-1:0]   len_sat;

    // Clamp the requested length to the exponent register width
    always_comb begin
        len_sat = len_in;
        if (len_in > LEN_W'(E_WIDTH)) begin
            len_sat = LEN_W'(E_WIDTH);
        end
    end

    // Latch exponent on load, then step the bit index downwards
    always_ff @(posedge clk) begin
        if (!resetn) begin
            e_bits   <= '0;
            idx      <= '0;
            len_zero <= 1'b1;
        end else if (load) begin
            e_bits   <= e_in;
            idx      <= IDX_W'(len_sat - LEN_W'(1));
            len_zero <= (len_sat == '0);
        end else if (step && (idx != '0)) begin
            idx <= idx - IDX_W'(1);
        end
    end

    assign cur_bit  = e_bits[idx];
    assign last_bit = (idx == '0);

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply modular exponentiation sequencer that
// drives an external Montgomery multiplier over a start/operands/done handshake.
// Optional build macro: MODEXP_CONST_TIME_EN (MUL issued for every exponent bit).
module modexp_ctrl
    import modexp_pkg::*;
#(
    parameter int WIDTH   = 1024,
    parameter int E_WIDTH = 1024
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic [WIDTH-1:0]         in_x,
    input  logic [E_WIDTH-1:0]       in_e,
    input  logic [$clog2(E_WIDTH):0] in_e_len,
    input  logic [WIDTH-1:0]         in_m,
    input  logic [WIDTH-1:0]         in_r,
    input  logic [WIDTH-1:0]         in_r2,
    output logic [WIDTH-1:0]         result,
    output logic                     done,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    output logic [WIDTH-1:0]         mul_m,
    input  logic [WIDTH-1:0]         mul_result,
    input  logic                     mul_done
);

    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(ONE);

    logic [2:0]       state;
    logic             phase;
    logic [WIDTH-1:0] x_lat;
    logic [WIDTH-1:0] m_lat;
    logic [WIDTH-1:0] r2_lat;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] xt;

    logic             load;
    logic             step;
    logic             capture;
    logic             do_mul;
    logic             cur_bit;
    logic             last_bit;
    logic             len_zero;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    function automatic logic [WIDTH-1:0] operand(
        input logic [2:0]       sel,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] r2,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] t
    );
        logic [WIDTH-1:0] v;
        case (sel)
            SEL_X:   v = x;
            SEL_R2:  v = r2;
            SEL_ACC: v = a;
            SEL_XT:  v = t;
            default: v = ONE_W;
        endcase
        return v;
    endfunction

    modexp_ebit_iter #(
        .E_WIDTH (E_WIDTH)
    ) u_iter (
        .clk      (clk),
        .resetn   (resetn),
        .load     (load),
        .e_in     (in_e),
        .len_in   (in_e_len),
        .step     (step),
        .cur_bit  (cur_bit),
        .last_bit (last_bit),
        .len_zero (len_zero)
    );

    // Handshake decode: a done is only taken after the cycle carrying mul_start
    always_comb begin
`ifdef MODEXP_CONST_TIME_EN
        do_mul = 1'b1;
`else
        do_mul = cur_bit;
`endif
        load    = (state == IDLE) && start;
        capture = (phase == WAIT) && !mul_start && mul_done;
        step    = 1'b0;
        if (capture && !last_bit) begin
            if ((state == SQ && !do_mul) || (state == MUL)) begin
                step = 1'b1;
            end
        end
        op_a = operand(sel_a(state), x_lat, r2_lat, acc, xt);
        op_b = operand(sel_b(state), x_lat, r2_lat, acc, xt);
    end

    // Main sequencer: latch on start, issue/wait per multiply, publish result
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            phase     <= ISSUE;
            x_lat     <= '0;
            m_lat     <= '0;
            r2_lat    <= '0;
            acc       <= '0;
            xt        <= '0;
            result    <= '0;
            done      <= 1'b0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_m     <= '0;
        end else begin
            done      <= 1'b0;
            mul_start <= 1'b0;
            case (state)
                IDLE: begin
                    phase <= ISSUE;
                    if (start) begin
                        x_lat  <= in_x;
                        m_lat  <= in_m;
                        r2_lat <= in_r2;
                        acc    <= in_r;
                        state  <= TO_MONT;
                    end
                end
                TO_MONT, SQ, MUL, FROM_MONT: begin
                    if (phase == ISSUE) begin
                        mul_a     <= op_a;
                        mul_b     <= op_b;
                        mul_m     <= m_lat;
                        mul_start <= 1'b1;
                        phase     <= WAIT;
                    end else if (capture) begin
                        phase <= ISSUE;
                        case (state)
                            TO_MONT: begin
                                xt    <= mul_result;
                                state <= len_zero ? FROM_MONT : SQ;
                            end
                            SQ: begin
                                acc <= mul_result;
                                if (do_mul) begin
                                    state <= MUL;
                                end else if (last_bit) begin
                                    state <= FROM_MONT;
                                end
                            end
                            MUL: begin
                                // In constant-time builds a zero bit discards the product
                                if (cur_bit) begin
                                    acc <= mul_result;
                                end
                                state <= last_bit ? FROM_MONT : SQ;
                            end
                            default: begin
                                acc   <= mul_result;
                                state <= FIN;
                            end
                        endcase
                    end
                end
                FIN: begin
                    result <= acc;
                    done   <= 1'b1;
                    phase  <= ISSUE;
                    state  <= IDLE;
                end
                default: begin
                    phase <= ISSUE;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Self-checking bench for modexp_ctrl with WIDTH=8, m=13 and a behavioural
// Montgomery multiplier. Honours MODEXP_CONST_TIME_EN for expected op counts.
module tb_modexp_ctrl;

`ifdef MODEXP_CONST_TIME_EN
    localparam bit CT = 1'b1;
`else
    localparam bit CT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [7:0] in_x, in_e, in_m, in_r, in_r2;
    logic [3:0] in_e_len;
    logic [7:0] result;
    logic       done;
    logic       mul_start;
    logic [7:0] mul_a, mul_b, mul_m;
    logic [7:0] mul_result;
    logic       mul_done;

    modexp_ctrl #(.WIDTH(8), .E_WIDTH(8)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .in_x       (in_x),
        .in_e       (in_e),
        .in_e_len   (in_e_len),
        .in_m       (in_m),
        .in_r       (in_r),
        .in_r2      (in_r2),
        .result     (result),
        .done       (done),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_m      (mul_m),
        .mul_result (mul_result),
        .mul_done   (mul_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [7:0] e;
        logic [3:0] len;
        int         hold;
        bit         mid;
        logic [7:0] exp_res;
        int         exp_ops;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    int pass_cnt = 0;
    int total_cnt = 0;
    int ops_cnt = 0;
    int done_cnt = 0;
    int unstable = 0;
    int hold_cfg = 1;
    int lat_left = 0;
    int hold_left = 0;
    bit busy = 1'b0;
    logic [7:0] cap_a, cap_b, cap_m;

    // Behavioural Montgomery product a*b*2^-8 mod m (bit-serial REDC)
    function automatic logic [7:0] mm(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
        longint t;
        t = longint'(a) * longint'(b);
        for (int i = 0; i < 8; i++) begin
            if (t[0]) t = t + longint'(m);
            t = t >>> 1;
        end
        if (t >= longint'(m)) t = t - longint'(m);
        return t[7:0];
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Multiplier model plus pulse counters and operand-stability monitor
    always @(negedge clk) begin
        if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) mul_done = 1'b0;
        end
        if (lat_left > 0) begin
            lat_left--;
            if (lat_left == 0) begin
                mul_result = mm(cap_a, cap_b, cap_m);
                mul_done   = 1'b1;
                hold_left  = hold_cfg;
                busy       = 1'b0;
            end
        end
        if (mul_start) begin
            ops_cnt++;
            cap_a    = mul_a;
            cap_b    = mul_b;
            cap_m    = mul_m;
            lat_left = 3;
            busy     = 1'b1;
        end else if (busy && (mul_a != cap_a || mul_b != cap_b || mul_m != cap_m)) begin
            unstable++;
        end
        if (done) done_cnt++;
    end

    task automatic set_vec(input int i, input logic [7:0] x, input logic [7:0] e, input logic [3:0] len,
                           input int hold, input bit mid, input logic [7:0] res, input int ops_plain,
                           input int ops_ct);
        vecs[i].x       = x;
        vecs[i].e       = e;
        vecs[i].len     = len;
        vecs[i].hold    = hold;
        vecs[i].mid     = mid;
        vecs[i].exp_res = res;
        vecs[i].exp_ops = CT ? ops_ct : ops_plain;
    endtask

    task automatic load_inputs(input vec_t v);
        in_x = v.x; in_e = v.e; in_e_len = v.len;
        in_m = 8'd13; in_r = 8'd9; in_r2 = 8'd3;
    endtask

    task automatic scramble_inputs();
        in_x = 8'hAA; in_e = 8'h55; in_e_len = 4'd7;
        in_m = 8'h0F; in_r = 8'h21; in_r2 = 8'h42;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        bit   seen;
        bit   pulsed;
        int   n;
        logic [7:0] res_at_done;
        string nm;
        v = vecs[idx];
        nm = $sformatf("vec%0d", idx);
        seen = 1'b0; pulsed = 1'b0; n = 0; res_at_done = 8'hFF;
        hold_cfg = v.hold;
        @(negedge clk);
        load_inputs(v);
        ops_cnt = 0; done_cnt = 0; unstable = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble_inputs();
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if (done) begin
                seen = 1'b1;
                res_at_done = result;
            end
            if (v.mid && !pulsed && ops_cnt >= 3) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({nm, "_done_seen"}, longint'(seen), 1);
        repeat (8) @(negedge clk);
        check({nm, "_result_at_done"}, longint'(res_at_done), longint'(v.exp_res));
        check({nm, "_result_held"}, longint'(result), longint'(v.exp_res));
        check({nm, "_mul_starts"}, longint'(ops_cnt), longint'(v.exp_ops));
        check({nm, "_done_pulses"}, longint'(done_cnt), 1);
        check({nm, "_operands_stable"}, longint'(unstable), 0);
        $display("%s x=%0d e=%0d len=%0d -> result=%0d ops=%0d done_pulses=%0d",
                 nm, v.x, v.e, v.len, res_at_done, ops_cnt, done_cnt);
    endtask

    initial begin
        int n;
        //           idx x      e       len    hold mid res    plain ct
        set_vec(0, 8'd2,  8'd5,   4'd3,  1, 0, 8'd6,  7,  8);
        set_vec(1, 8'd7,  8'd1,   4'd1,  1, 0, 8'd7,  4,  4);
        set_vec(2, 8'd7,  8'd1,   4'd0,  1, 0, 8'd1,  2,  2);
        set_vec(3, 8'd2,  8'd7,   4'd3,  1, 0, 8'd11, 8,  8);
        set_vec(4, 8'd5,  8'd10,  4'd4,  1, 0, 8'd12, 8,  10);
        set_vec(5, 8'd0,  8'd3,   4'd2,  1, 0, 8'd0,  6,  6);
        set_vec(6, 8'd2,  8'd5,   4'd5,  1, 0, 8'd6,  9,  12);
        set_vec(7, 8'd2,  8'd255, 4'd15, 1, 0, 8'd8,  18, 18);
        set_vec(8, 8'd2,  8'd5,   4'd3,  3, 1, 8'd6,  7,  8);
        set_vec(9, 8'd12, 8'd2,   4'd2,  3, 0, 8'd1,  5,  6);

        mul_done = 1'b0; mul_result = 8'd0;
        start = 1'b0; resetn = 1'b0;
        scramble_inputs();
        repeat (3) @(negedge clk);
        check("reset_result", longint'(result), 0);
        check("reset_done", longint'(done), 0);
        check("reset_mul_start", longint'(mul_start), 0);
        check("reset_mul_a", longint'(mul_a), 0);
        check("reset_mul_b", longint'(mul_b), 0);
        check("reset_mul_m", longint'(mul_m), 0);
        $display("reset: result=%0d done=%0d mul_start=%0d", result, done, mul_start);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i);
        end

        // Abort during the SQ wait phase; the pending mul_done must be ignored
        hold_cfg = 1;
        @(negedge clk);
        load_inputs(vecs[0]);
        ops_cnt = 0; done_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (ops_cnt < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_sq", longint'(ops_cnt), 2);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        ops_cnt = 0; done_cnt = 0;
        repeat (10) @(negedge clk);
        check("abort_no_ops", longint'(ops_cnt), 0);
        check("abort_no_done", longint'(done_cnt), 0);
        check("abort_result", longint'(result), 0);
        check("abort_mul_a", longint'(mul_a), 0);
        check("abort_mul_b", longint'(mul_b), 0);
        check("abort_mul_m", longint'(mul_m), 0);
        $display("abort: ops_after=%0d done_after=%0d result=%0d", ops_cnt, done_cnt, result);
        run_vec(0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
